axis_fifo_buffer: RTL and testbench



---
 rtl/axis_fifo_buffer.sv | 101 ++++++++++
 tb/tb_axis_fifo_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_buffer.sv
// AXI4-Stream register FIFO with tlast pass-through, occupancy count,
// programmable-full flag and synchronous flush.
module axis_fifo_buffer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DEPTH            = 4,
    parameter int PROG_FULL        = 3
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          flush,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          prog_full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = AXIS_TDATA_WIDTH + 1;

    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PROG_FULL_C = CNT_W'(PROG_FULL);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             s_ready_q, s_ready_d;
    logic             prog_full_q, prog_full_d;

    logic push;
    logic pop;
    logic wr_en;

    assign push  = s_axis_tvalid & s_ready_q;
    assign pop   = m_axis_tvalid & m_axis_tready;
    // A beat presented alongside flush is discarded, so it is never written.
    assign wr_en = push & ~flush & ~areset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        // Ready and prog_full look at the next count so they line up with it.
        s_ready_d   = (count_d != DEPTH_C);
        prog_full_d = (count_d >= PROG_FULL_C);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s_ready_q   <= 1'b0;
            prog_full_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            s_ready_q   <= s_ready_d;
            prog_full_q <= prog_full_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    assign {m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];
    assign m_axis_tvalid = (count_q != '0);
    assign s_axis_tready = s_ready_q;
    assign count         = count_q;
    assign prog_full     = prog_full_q;

endmodule

// File: tb/tb_axis_fifo_buffer.sv
// Bench for axis_fifo_buffer (DEPTH=4, PROG_FULL=3): directed phases drive the
// FIFO while a negedge scoreboard checks every output beat, count and stalls.
module tb_axis_fifo_buffer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          areset;
    logic          flush;
    logic [W-1:0]  s_tdata;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [W-1:0]  m_tdata;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [2:0]    count;
    logic          prog_full;

    axis_fifo_buffer #(
        .AXIS_TDATA_WIDTH(W),
        .DEPTH(4),
        .PROG_FULL(3)
    ) dut (
        .aclk(clk),
        .areset(areset),
        .flush(flush),
        .s_axis_tdata(s_tdata),
        .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .count(count),
        .prog_full(prog_full)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];
    int         model_cnt = 0;
    int         popped    = 0;
    bit         mon_en    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples on negedge, between drive (posedge+1) and the next edge.
    initial begin : monitor
        bit         prev_stall;
        logic [W:0] prev_beat;
        logic [W:0] exp_beat;
        prev_stall = 0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("count_vs_model", 64'(count), 64'(model_cnt));
                chk("prog_full_vs_model", 64'(prog_full), 64'(model_cnt >= 3));
                if (prev_stall) begin
                    chk("stall_tvalid", 64'(m_tvalid), 64'(1));
                    chk("stall_beat", 64'({m_tlast, m_tdata}), 64'(prev_beat));
                end
                if (areset || flush) begin
                    exp_q.delete();
                    model_cnt = 0;
                end else begin
                    if (m_tvalid && m_tready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t", m_tdata, $time);
                        end else begin
                            exp_beat = exp_q.pop_front();
                            chk("out_beat", 64'({m_tlast, m_tdata}), 64'(exp_beat));
                        end
                        popped++;
                        model_cnt--;
                    end
                    if (s_tvalid && s_tready) begin
                        exp_q.push_back({s_tlast, s_tdata});
                        model_cnt++;
                    end
                end
                prev_stall = m_tvalid && !m_tready && !areset && !flush;
                prev_beat  = {m_tlast, m_tdata};
            end
        end
    end

    initial begin : stim
        logic [W-1:0] fill_vals [4];
        int exp_cnt [4];
        int exp_pf  [4];
        int exp_rdy [4];
        int base_popped;
        int beat_idx;
        int cycles;
        bit acc;

        fill_vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        exp_cnt   = '{1, 2, 3, 4};
        exp_pf    = '{0, 0, 1, 1};
        exp_rdy   = '{1, 1, 1, 0};

        areset   = 1'b1;
        flush    = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;

        // Reset: three cycles held high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_tready", 64'(s_tready), 64'(0));
            chk("rst_tvalid", 64'(m_tvalid), 64'(0));
            chk("rst_count", 64'(count), 64'(0));
            chk("rst_prog_full", 64'(prog_full), 64'(0));
        end
        areset = 1'b0;
        mon_en = 1;
        #1;
        chk("release_tready_still_low", 64'(s_tready), 64'(0));
        step();
        chk("release_tready_high", 64'(s_tready), 64'(1));
        chk("release_tvalid", 64'(m_tvalid), 64'(0));

        // Fill with sink stalled
        for (int i = 0; i < 4; i++) begin
            s_tdata  = fill_vals[i];
            s_tvalid = 1'b1;
            step();
            chk("fill_count", 64'(count), 64'(exp_cnt[i]));
            chk("fill_prog_full", 64'(prog_full), 64'(exp_pf[i]));
            chk("fill_tready", 64'(s_tready), 64'(exp_rdy[i]));
        end
        // Offered beat while full must not be taken
        s_tdata = 32'h55;
        step();
        chk("full_no_accept_count", 64'(count), 64'(4));
        s_tvalid = 1'b0;

        // One pop at full: ready returns the next cycle
        chk("full_head", 64'(m_tdata), 64'h11);
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        chk("full_pop_count", 64'(count), 64'(3));
        chk("full_pop_tready", 64'(s_tready), 64'(1));

        // Drain the rest, one per cycle
        m_tready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk("drain_tvalid", 64'(m_tvalid), 64'(1));
            chk("drain_data", 64'(m_tdata), 64'(fill_vals[i]));
            step();
            chk("drain_count", 64'(count), 64'(3 - i));
        end
        chk("drain_empty", 64'(m_tvalid), 64'(0));

        // Streaming: 1000 beats, count pinned at 1
        base_popped = popped;
        s_tvalid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            s_tdata = 32'h1000_0000 + 32'(i);
            s_tlast = (i % 7 == 6);
            step();
            chk("stream_count", 64'(count), 64'(1));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        step();
        chk("stream_drained", 64'(count), 64'(0));
        chk("stream_total", 64'(popped - base_popped), 64'(1000));

        // Random backpressure with tlast every 7th beat
        beat_idx = 0;
        cycles   = 0;
        while (beat_idx < 4000 && cycles < 40000) begin
            s_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = $urandom;
            s_tlast  = (beat_idx % 7 == 6);
            acc = s_tvalid && s_tready;
            // Hold the offered beat until it is accepted
            if (s_tvalid) begin
                while (!acc && cycles < 40000) begin
                    step();
                    cycles++;
                    m_tready = 1'($urandom_range(0, 1));
                    acc = s_tready;
                end
                step();
                cycles++;
                beat_idx++;
            end else begin
                step();
                cycles++;
            end
        end
        chk("random_budget", 64'(beat_idx), 64'(4000));
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("random_drained", 64'(count), 64'(0));
        chk("random_queue_empty", 64'(exp_q.size()), 64'(0));

        // Flush with simultaneous push and pop
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 32'hB0 + 32'(i);
            step();
        end
        chk("preflush_count", 64'(count), 64'(3));
        flush    = 1'b1;
        s_tdata  = 32'hAA;
        m_tready = 1'b1;
        step();
        flush    = 1'b0;
        s_tvalid = 1'b0;
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_tvalid", 64'(m_tvalid), 64'(0));
        chk("flush_tready", 64'(s_tready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postflush_tvalid", 64'(m_tvalid), 64'(0));
        end

        // Post-flush sanity: FIFO still works from a clean state
        s_tvalid = 1'b1;
        s_tdata  = 32'hC0DE;
        m_tready = 1'b0;
        step();
        s_tvalid = 1'b0;
        chk("postflush_data", 64'(m_tdata), 64'hC0DE);
        m_tready = 1'b1;
        step();
        chk("postflush_empty", 64'(count), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
